// File: rtl/edge_filter_fsm_if.sv
// Event-detector bus: enable, filter length and raw inputs in; filtered level and pulses out.
// Master is the event source/consumer side; slave is the filter.
interface edge_filter_fsm_if #(
  parameter int NCH    = 4,
  parameter int FILT_W = 4
);
  logic              en;
  logic [FILT_W-1:0] filt_len;
  logic [NCH-1:0]    din;
  logic [NCH-1:0]    level;
  logic [NCH-1:0]    rise;
  logic [NCH-1:0]    fall;
  logic [NCH-1:0]    glitch;

  modport master (
    output en, filt_len, din,
    input  level, rise, fall, glitch
  );

  modport slave (
    input  en, filt_len, din,
    output level, rise, fall, glitch
  );
endinterface

// File: rtl/edge_filter_fsm.sv
// Per-channel glitch filter: a level is accepted after filt_len+1 equal samples, then a registered
// one-cycle rise/fall pulse is emitted (glitch on abort); no backpressure, outputs are free-running.
module edge_filter_fsm #(
  parameter int NCH    = 4,
  parameter int FILT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  edge_filter_fsm_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM_HI = 2'd1,
    RUN    = 2'd2,
    ARM_LO = 2'd3
  } state_e;

  state_e            state_q [NCH];
  state_e            state_d [NCH];
  logic [FILT_W-1:0] cnt_q   [NCH];
  logic [FILT_W-1:0] cnt_d   [NCH];

  logic [NCH-1:0] level_q, rise_q, fall_q, glitch_q;
  logic [NCH-1:0] level_d, rise_d, fall_d, glitch_d;

  logic f_zero;
  assign f_zero = (bus.filt_len == '0);

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!bus.en) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        // cnt >= F (not ==) so a lowered filt_len completes a pending transition at once
        case (state_q[i])
          IDLE: begin
            if (bus.din[i]) begin
              if (f_zero) begin
                state_d[i] = RUN;
              end else begin
                state_d[i] = ARM_HI;
                cnt_d[i]   = {{(FILT_W-1){1'b0}}, 1'b1};
              end
            end
          end
          ARM_HI: begin
            if (!bus.din[i])                  state_d[i] = IDLE;
            else if (cnt_q[i] >= bus.filt_len) state_d[i] = RUN;
            else                              cnt_d[i]   = cnt_q[i] + 1'b1;
          end
          RUN: begin
            if (!bus.din[i]) begin
              if (f_zero) begin
                state_d[i] = IDLE;
              end else begin
                state_d[i] = ARM_LO;
                cnt_d[i]   = {{(FILT_W-1){1'b0}}, 1'b1};
              end
            end
          end
          ARM_LO: begin
            if (bus.din[i])                   state_d[i] = RUN;
            else if (cnt_q[i] >= bus.filt_len) state_d[i] = IDLE;
            else                              cnt_d[i]   = cnt_q[i] + 1'b1;
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  // Pulses are gated by en so a forced return to IDLE never reports a fall
  always_comb begin
    level_d  = '0;
    rise_d   = '0;
    fall_d   = '0;
    glitch_d = '0;
    for (int i = 0; i < NCH; i++) begin
      level_d[i]  = (state_d[i] == RUN) || (state_d[i] == ARM_LO);
      rise_d[i]   = bus.en && (state_d[i] == RUN) &&
                    (state_q[i] == IDLE || state_q[i] == ARM_HI);
      fall_d[i]   = bus.en && (state_d[i] == IDLE) &&
                    (state_q[i] == RUN || state_q[i] == ARM_LO);
      glitch_d[i] = bus.en &&
                    (((state_q[i] == ARM_HI) && (state_d[i] == IDLE)) ||
                     ((state_q[i] == ARM_LO) && (state_d[i] == RUN)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      glitch_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign bus.level  = level_q;
  assign bus.rise   = rise_q;
  assign bus.fall   = fall_q;
  assign bus.glitch = glitch_q;

`ifndef SYNTHESIS
  logic [47:0] state_name_unused [NCH];
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      case (state_q[i])
        IDLE:    state_name_unused[i] = "IDLE  ";
        ARM_HI:  state_name_unused[i] = "ARM_HI";
        RUN:     state_name_unused[i] = "RUN   ";
        ARM_LO:  state_name_unused[i] = "ARM_LO";
        default: state_name_unused[i] = "??????";
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_edge_filter_fsm.sv
// Directed bench for edge_filter_fsm: hand-computed level/rise/fall/glitch vectors per step.
module tb_edge_filter_fsm;

  localparam int NCH    = 4;
  localparam int FILT_W = 4;

  logic clk;
  logic rst_n;

  int n_assert;
  int n_fail;

  edge_filter_fsm_if #(.NCH(NCH), .FILT_W(FILT_W)) bus ();

  edge_filter_fsm #(.NCH(NCH), .FILT_W(FILT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [NCH-1:0] lvl, input logic [NCH-1:0] r,
                         input logic [NCH-1:0] f, input logic [NCH-1:0] g);
    chk({tag, ".level"},  bus.level,  lvl);
    chk({tag, ".rise"},   bus.rise,   r);
    chk({tag, ".fall"},   bus.fall,   f);
    chk({tag, ".glitch"}, bus.glitch, g);
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.filt_len = '0;
    bus.din      = '0;

    ticks(2);
    chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    tick();

    // 1: F=0, single-cycle high on ch0
    bus.en       = 1'b1;
    bus.filt_len = 4'd0;
    bus.din      = 4'b0001;
    tick();
    chk_all("t1_rise", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    bus.din = 4'b0000;
    tick();
    chk_all("t1_fall", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    tick();
    chk_all("t1_quiet", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // 2: F=3, ch1 accepted after 4 samples each way
    bus.filt_len = 4'd3;
    bus.din      = 4'b0010;
    ticks(3);
    chk_all("t2_arm_hi", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    chk_all("t2_rise", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    tick();
    chk_all("t2_rise_1cyc", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    bus.din = 4'b0000;
    ticks(3);
    chk_all("t2_arm_lo", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tick();
    chk_all("t2_fall", 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    tick();
    chk_all("t2_fall_1cyc", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // 3: F=3, aborted rise on ch2, then aborted fall from RUN
    bus.din = 4'b0100;
    ticks(3);
    chk_all("t3_short_hi", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    bus.din = 4'b0000;
    tick();
    chk_all("t3_glitch_hi", 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    tick();
    chk_all("t3_glitch_hi_1cyc", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    bus.din = 4'b0100;
    ticks(4);
    chk_all("t3_rise", 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    tick();
    bus.din = 4'b0000;
    ticks(2);
    chk_all("t3_dip", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    bus.din = 4'b0100;
    tick();
    chk_all("t3_glitch_lo", 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    tick();
    chk_all("t3_hold", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    bus.din = 4'b0000;
    ticks(4);
    chk_all("t3_fall", 4'b0000, 4'b0000, 4'b0100, 4'b0000);

    // 4: F=5, simultaneous rise on ch0/ch3 and fall on ch1
    bus.filt_len = 4'd5;
    bus.din      = 4'b0010;
    ticks(6);
    chk_all("t4_ch1_run", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    bus.din = 4'b1001;
    ticks(5);
    chk_all("t4_pending", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tick();
    chk_all("t4_simul", 4'b1001, 4'b1001, 4'b0010, 4'b0000);
    bus.en = 1'b0;
    tick();
    chk_all("t4_en_off", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // 5: F=7 lowered to 1 mid-count, then en=0 from RUN
    bus.din      = 4'b0000;
    bus.en       = 1'b1;
    bus.filt_len = 4'd7;
    tick();
    bus.din = 4'b0001;
    ticks(2);
    chk_all("t5_cnt2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    bus.filt_len = 4'd1;
    tick();
    chk_all("t5_short_rise", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tick();
    chk_all("t5_run", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    bus.en = 1'b0;
    tick();
    chk_all("t5_en_drop", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // 6: async reset mid-ARM_HI, then full re-qualification with F=2
    bus.en       = 1'b1;
    bus.filt_len = 4'd2;
    bus.din      = 4'b0001;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("t6_async_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    ticks(2);
    chk_all("t6_requal", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    chk_all("t6_rise", 4'b0001, 4'b0001, 4'b0000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
